data_memory_arbiter: RTL
========================

Name: data_memory_arbiter

Overview:
Shares the single-port synchronous data memory between two requesters. Requester 0 is the core load/store unit. Requester 1 is the debug/DMA port. The block uses round-robin arbitration, drives the memory address, write-data and write-enable inputs, and routes the 1-cycle synchronous read data back to the owning requester with a valid pulse. Out-of-range accesses are rejected with an error response and never reach the memory.

Parameters:
DEPTH, 4096, number of 32-bit words in the memory; legal word addresses are 0..DEPTH-1
DATA_W, 32, data width of requesters and memory
ADDR_W, 32, word-address width of requesters and memory

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has a transaction
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  word address
req0_wdata  in  DATA_W  write data
req0_ready  out  1  transaction accepted this cycle (combinational)
rsp0_valid  out  1  response for requester 0 (one cycle after accept)
rsp0_rdata  out  DATA_W  read data; 0 for writes and errors
rsp0_err  out  1  address out of range
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err: same as requester 0, for requester 1
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  DATA_W  to memory write_data
mem_we  out  1  to memory write_enable
mem_rdata  in  DATA_W  from memory synchronous read output

Behaviour:
- Requester contract: valid held with addr/we/wdata stable until ready=1. Handshake completes on the cycle with valid & ready.
- Arbitration (combinational, every cycle):
  - Only one valid: it is granted.
  - Both valid: grant the requester not granted most recently.
  - last_grant register updates only on an accepted handshake.
  - Reset value of last_grant = 1, so requester 0 wins the first conflict.
- At most one accept per cycle. Back-to-back accepts are allowed every cycle; there are no bubbles.
- Memory drive in the accept cycle N (combinational from the granted request):
  - mem_addr = addr, mem_wdata = wdata.
  - mem_we = we & in_range.
- Memory drive with no accept, or with an out-of-range accept: mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - A read of word 0 is harmless.
- in_range = addr < DEPTH, compared over the full ADDR_W width with unsigned compare. Address DEPTH-1 is legal; DEPTH is an error.
- Response stage registers at end of cycle N: pending, owner, was_write, err.
- Cycle N+1 response:
  - rspX_valid = 1 for the owner only.
  - rdata = mem_rdata for an in-range read; 0 for writes and errors. The memory does not update its read register on write cycles, so mem_rdata is ignored for writes.
  - err = 1 iff out of range.
- Read-after-write to the same address in consecutive cycles returns the new data. The memory write completes at posedge N; the read in N+1 samples it at posedge N+1.
- Responses never collide: one accept per cycle gives at most one response per cycle.
- Reset (synchronous; takes priority over all other activity):
  - All rsp*_valid, rsp*_err and rsp*_rdata = 0; pending = 0.
  - A transaction accepted in the cycle rst is sampled produces no response.
  - While rst = 1: req*_ready = 0 and mem_we = 0.
- No internal queue. A denied requester simply waits, holding valid.

Decomposition:
- Package data_mem_arb_pkg:
  - localparams DEPTH, DATA_W, ADDR_W.
  - typedef mem_req_t struct {we, addr, wdata}.
  - typedef enum logic {OWNER_0, OWNER_1} owner_e.
- Sub-module rr_arbiter_2: inputs valid[1:0] and accept; outputs grant[1:0]; holds the last_grant register.
- Top level contains the mux, range check and response stage.

Test Plan:
- Reset, then req0 writes 0xDEADBEEF to addr 5 -> req0_ready=1 in cycle N; mem_we=1, mem_addr=5; rsp0_valid=1, rsp0_err=0, rsp0_rdata=0 in N+1.
- req0 write 0x12345678 to addr 7 in cycle N, then read addr 7 in cycle N+1 -> in N+2, rsp0_rdata=0x12345678.
- Both requesters valid continuously with reads of addr 1 and addr 2 -> grants alternate 0,1,0,1 starting with 0; responses alternate owner each cycle with correct data.
- req1 read addr 4096, then write addr 0xFFFFFFFF -> mem_we=0 both times; rsp1_err=1, rsp1_rdata=0; read at addr 4095 gives err=0.
- req0 accepted in cycle N with rst=1 in N -> no rsp0_valid in N+1; after rst, req1 alone is granted immediately; on the first conflict, requester 0 wins.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and default sizing for the data memory arbiter.
package data_mem_arb_pkg;

    localparam int DEPTH  = 4096;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic {
        OWNER_0 = 1'b0,
        OWNER_1 = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the remembered winner only moves on an accepted handshake.
module rr_arbiter_2
    import data_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    owner_e r_last_grant;

    // Reset to requester 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= OWNER_1;
        end else if (accept) begin
            r_last_grant <= grant[1] ? OWNER_1 : OWNER_0;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (r_last_grant == OWNER_1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port synchronous data memory between the LSU (req0) and debug/DMA (req1).
module data_memory_arbiter #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    import data_mem_arb_pkg::*;

    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    logic [1:0]        w_ready;
    logic              w_accept;
    logic              w_in_range;
    owner_e            w_owner;
    mem_req_t          w_req;
    logic [DATA_W-1:0] w_rsp_data;

    logic   r_pending;
    owner_e r_owner;
    logic   r_was_write;
    logic   r_err;

    assign w_valid = {req1_valid, req0_valid};

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  (w_valid),
        .accept (w_accept),
        .grant  (w_grant)
    );

    assign w_ready    = rst ? 2'b00 : w_grant;
    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign w_accept   = |(w_valid & w_ready);
    assign w_owner    = w_grant[1] ? OWNER_1 : OWNER_0;

    always_comb begin
        w_req = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
        if (w_owner == OWNER_1) begin
            w_req = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
        end
    end

    assign w_in_range = w_req.addr < ADDR_W'(DEPTH);

    // Idle and rejected cycles park the bus on a harmless read of word 0.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (w_accept && w_in_range) begin
            mem_addr  = w_req.addr;
            mem_wdata = w_req.wdata;
            mem_we    = w_req.we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= 1'b0;
            r_owner     <= OWNER_0;
            r_was_write <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pending <= w_accept;
            if (w_accept) begin
                r_owner     <= w_owner;
                r_was_write <= w_req.we;
                r_err       <= ~w_in_range;
            end
        end
    end

    // The memory holds its read register on writes, so mem_rdata is stale then.
    assign w_rsp_data = (r_pending && !r_was_write && !r_err) ? mem_rdata : '0;

    assign rsp0_valid = r_pending && (r_owner == OWNER_0);
    assign rsp1_valid = r_pending && (r_owner == OWNER_1);
    assign rsp0_rdata = rsp0_valid ? w_rsp_data : '0;
    assign rsp1_rdata = rsp1_valid ? w_rsp_data : '0;
    assign rsp0_err   = rsp0_valid && r_err;
    assign rsp1_err   = rsp1_valid && r_err;

endmodule
